calpoc_calc_core: RTL and testbench



---
 rtl/calpoc_calc_core.sv | 210 +++++++++++++++++++++
 tb/tb_calpoc_calc_core.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calpoc_calc_core.sv
// calpoc_calc_core: WIDTH-bit button-driven calculator (OR, XOR, AND, ADD).
// Owns operand entry, operation select, the result hold and result chaining.
// Optional macro CALPOC_EDGE_DETECT_EN: when defined, each button becomes a
// one-cycle press pulse. When undefined, the button level acts every cycle.
module calpoc_calc_core #(
    parameter int WIDTH = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ButtonFor0,
    input  logic             ButtonFor1,
    input  logic             ButtonForOR,
    input  logic             ButtonForXOR,
    input  logic             ButtonForAND,
    input  logic             ButtonForADD,
    input  logic             ButtonForEquals,
    input  logic             ButtonForClear,
    output logic [WIDTH-1:0] LEDForA,
    output logic [WIDTH-1:0] LEDForB,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             ResultValid,
    output logic [1:0]       State
);

    typedef enum logic [1:0] {
        ST_ARG1   = 2'b00,
        ST_ARG2   = 2'b01,
        ST_UNUSED = 2'b10,
        ST_OUTPUT = 2'b11
    } state_t;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    // Shift one digit into an operand from the LSB side; the MSB falls off.
    // For WIDTH=1 the shift leaves zero, so the operand becomes the digit.
    function automatic logic [WIDTH-1:0] shift_digit(input logic [WIDTH-1:0] r,
                                                     input logic             d);
        logic [WIDTH-1:0] t;
        t    = r << 1'b1;
        t[0] = d;
        return t;
    endfunction

    // Compute the result. The top bit is the ADD carry. It is 0 for logic ops.
    function automatic logic [WIDTH:0] alu(input logic [1:0]       op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
        logic [WIDTH:0] y;
        case (op)
            OP_OR:   y = {1'b0, a | b};
            OP_XOR:  y = {1'b0, a ^ b};
            OP_AND:  y = {1'b0, a & b};
            OP_ADD:  y = {1'b0, a} + {1'b0, b};
            default: y = {(WIDTH+1){1'b0}};
        endcase
        return y;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             carry_r;
    logic             valid_r;
    logic [1:0]       op_r;

    // Bit order {clear, d0, d1, or, xor, and, add, equals}, matching priority
    logic [7:0]       btn_s;
    logic [7:0]       pulse_s;
    logic             act_clear_s;
    logic             act_digit_s;
    logic             digit_s;
    logic             act_op_s;
    logic [1:0]       op_sel_s;
    logic             act_eq_s;
    logic [WIDTH-1:0] digit_ext_s;
    logic [WIDTH:0]   alu_s;

    assign btn_s = {ButtonForClear, ButtonFor0, ButtonFor1, ButtonForOR,
                    ButtonForXOR, ButtonForAND, ButtonForADD, ButtonForEquals};

`ifdef CALPOC_EDGE_DETECT_EN
    logic [7:0] prev_r;

    // Remember last cycle's button levels. A button held through reset fires once afterwards.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_r <= 8'h00;
        end else begin
            prev_r <= btn_s;
        end
    end

    assign pulse_s = btn_s & ~prev_r;
`else
    assign pulse_s = btn_s;
`endif

    assign alu_s = alu(op_r, a_r, b_r);

    // Pick the single winning action for this cycle and drop the lower-priority pulses.
    always_comb begin
        act_clear_s = 1'b0;
        act_digit_s = 1'b0;
        digit_s     = 1'b0;
        act_op_s    = 1'b0;
        op_sel_s    = OP_OR;
        act_eq_s    = 1'b0;
        if (pulse_s[7]) begin
            act_clear_s = 1'b1;
        end else if (pulse_s[6] | pulse_s[5]) begin
            act_digit_s = 1'b1;
            digit_s     = ~pulse_s[6];
        end else if (|pulse_s[4:1]) begin
            act_op_s = 1'b1;
            if (pulse_s[4]) begin
                op_sel_s = OP_OR;
            end else if (pulse_s[3]) begin
                op_sel_s = OP_XOR;
            end else if (pulse_s[2]) begin
                op_sel_s = OP_AND;
            end else begin
                op_sel_s = OP_ADD;
            end
        end else if (pulse_s[0]) begin
            act_eq_s = 1'b1;
        end else begin
            act_eq_s = 1'b0;
        end
        digit_ext_s    = {WIDTH{1'b0}};
        digit_ext_s[0] = digit_s;
    end

    // Calculator FSM: operand entry, op select, result latch and chaining.
    always_ff @(posedge CLK) begin
        if (RST || act_clear_s) begin
            state_r <= ST_ARG1;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            valid_r <= 1'b0;
            op_r    <= OP_OR;
        end else begin
            case (state_r)
                ST_ARG1: begin
                    if (act_digit_s) begin
                        a_r <= shift_digit(a_r, digit_s);
                    end else if (act_op_s) begin
                        op_r    <= op_sel_s;
                        state_r <= ST_ARG2;
                    end
                end
                ST_ARG2: begin
                    if (act_digit_s) begin
                        b_r <= shift_digit(b_r, digit_s);
                    end else if (act_op_s) begin
                        op_r <= op_sel_s;
                    end else if (act_eq_s) begin
                        res_r   <= alu_s[WIDTH-1:0];
                        carry_r <= alu_s[WIDTH];
                        valid_r <= 1'b1;
                        state_r <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (act_digit_s) begin
                        // Start a fresh calculation with the digit as the first entry
                        a_r     <= digit_ext_s;
                        b_r     <= {WIDTH{1'b0}};
                        res_r   <= {WIDTH{1'b0}};
                        carry_r <= 1'b0;
                        valid_r <= 1'b0;
                        state_r <= ST_ARG1;
                    end else if (act_op_s) begin
                        // Chain: the previous result becomes operand A
                        a_r     <= res_r;
                        b_r     <= {WIDTH{1'b0}};
                        op_r    <= op_sel_s;
                        carry_r <= 1'b0;
                        valid_r <= 1'b0;
                        state_r <= ST_ARG2;
                    end
                end
                default: begin
                    // The unused encoding recovers to a clean operand-A entry
                    state_r <= ST_ARG1;
                    a_r     <= {WIDTH{1'b0}};
                    b_r     <= {WIDTH{1'b0}};
                    res_r   <= {WIDTH{1'b0}};
                    carry_r <= 1'b0;
                    valid_r <= 1'b0;
                    op_r    <= OP_OR;
                end
            endcase
        end
    end

    assign LEDForA     = a_r;
    assign LEDForB     = b_r;
    assign Result      = res_r;
    assign Carry       = carry_r;
    assign ResultValid = valid_r;
    assign State       = state_r;

endmodule

// File: tb/tb_calpoc_calc_core.sv
// Self-checking bench for calpoc_calc_core (WIDTH=3), valid with or without
// CALPOC_EDGE_DETECT_EN. A cycle model pushes the expected outputs for each
// driven cycle. A negedge monitor pops and compares them. Scenario tasks also
// check fixed values inline.
module tb_calpoc_calc_core;

    localparam int W = 3;

    localparam logic [7:0] B_CLR = 8'h80;
    localparam logic [7:0] B_0   = 8'h40;
    localparam logic [7:0] B_1   = 8'h20;
    localparam logic [7:0] B_OR  = 8'h10;
    localparam logic [7:0] B_XOR = 8'h08;
    localparam logic [7:0] B_AND = 8'h04;
    localparam logic [7:0] B_ADD = 8'h02;
    localparam logic [7:0] B_EQ  = 8'h01;
    localparam logic [7:0] B_NONE = 8'h00;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic [1:0]   st;
        int           due;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST;
    logic [7:0]   btn;
    logic [W-1:0] LEDForA;
    logic [W-1:0] LEDForB;
    logic [W-1:0] Result;
    logic         Carry;
    logic         ResultValid;
    logic [1:0]   State;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state
    logic [W-1:0] m_a, m_b, m_res;
    logic         m_c, m_v;
    logic [1:0]   m_st, m_op;
    logic [7:0]   m_prev;

    calpoc_calc_core #(.WIDTH(W)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .ButtonFor0      (btn[6]),
        .ButtonFor1      (btn[5]),
        .ButtonForOR     (btn[4]),
        .ButtonForXOR    (btn[3]),
        .ButtonForAND    (btn[2]),
        .ButtonForADD    (btn[1]),
        .ButtonForEquals (btn[0]),
        .ButtonForClear  (btn[7]),
        .LEDForA         (LEDForA),
        .LEDForB         (LEDForB),
        .Result          (Result),
        .Carry           (Carry),
        .ResultValid     (ResultValid),
        .State           (State)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard monitor: compare every expectation whose edge has passed
    always @(negedge CLK) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            tests_run++;
            if (LEDForA !== mon_e.a || LEDForB !== mon_e.b || Result !== mon_e.res ||
                Carry !== mon_e.c || ResultValid !== mon_e.v || State !== mon_e.st) begin
                tests_failed++;
                $display("FAIL scoreboard cyc=%0d got A=%b B=%b R=%b C=%b V=%b S=%b want A=%b B=%b R=%b C=%b V=%b S=%b",
                         cyc, LEDForA, LEDForB, Result, Carry, ResultValid, State,
                         mon_e.a, mon_e.b, mon_e.res, mon_e.c, mon_e.v, mon_e.st);
            end
        end
    end

    task automatic model_clear();
        m_a = '0; m_b = '0; m_res = '0; m_c = 1'b0; m_v = 1'b0;
        m_st = 2'b00; m_op = 2'b00;
    endtask

    // Drive one cycle of inputs, advance the model, queue the expectation
    task automatic step(input logic rst, input logic [7:0] b);
        logic [7:0] p;
        logic       d;
        logic [W:0] sum;
        exp_t       e;
        RST = rst;
        btn = b;
        if (rst) begin
            model_clear();
            m_prev = 8'h00;
        end else begin
`ifdef CALPOC_EDGE_DETECT_EN
            p = b & ~m_prev;
            m_prev = b;
`else
            p = b;
`endif
            if (p[7]) begin
                model_clear();
            end else if (p[6] || p[5]) begin
                d = p[6] ? 1'b0 : 1'b1;
                if (m_st == 2'b00) begin
                    m_a = {m_a[W-2:0], d};
                end else if (m_st == 2'b01) begin
                    m_b = {m_b[W-2:0], d};
                end else begin
                    m_a = {{(W-1){1'b0}}, d};
                    m_b = '0; m_res = '0; m_c = 1'b0; m_v = 1'b0; m_st = 2'b00;
                end
            end else if (p[4:1] != 4'b0000) begin
                if (m_st == 2'b11) begin
                    m_a = m_res; m_b = '0; m_c = 1'b0; m_v = 1'b0;
                end
                m_op = p[4] ? 2'b00 : p[3] ? 2'b01 : p[2] ? 2'b10 : 2'b11;
                m_st = 2'b01;
            end else if (p[0] && m_st == 2'b01) begin
                case (m_op)
                    2'b00: begin m_res = m_a | m_b; m_c = 1'b0; end
                    2'b01: begin m_res = m_a ^ m_b; m_c = 1'b0; end
                    2'b10: begin m_res = m_a & m_b; m_c = 1'b0; end
                    default: begin
                        sum = {1'b0, m_a} + {1'b0, m_b};
                        m_res = sum[W-1:0];
                        m_c = sum[W];
                    end
                endcase
                m_v = 1'b1;
                m_st = 2'b11;
            end
        end
        e.a = m_a; e.b = m_b; e.res = m_res; e.c = m_c; e.v = m_v; e.st = m_st;
        e.due = cyc + 1;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [7:0] b);
        step(1'b0, b);
        step(1'b0, B_NONE);
    endtask

    task automatic test_reset();
        step(1'b1, B_NONE);
        step(1'b1, B_1 | B_EQ);
        tests_run++;
        if (LEDForA !== 3'b000 || LEDForB !== 3'b000 || Result !== 3'b000 ||
            Carry !== 1'b0 || ResultValid !== 1'b0 || State !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset got A=%b B=%b R=%b C=%b V=%b S=%b want all zero",
                     LEDForA, LEDForB, Result, Carry, ResultValid, State);
        end
        step(1'b0, B_NONE);
    endtask

    task automatic test_or_basic();
        press(B_1); press(B_0); press(B_1);
        press(B_OR);
        press(B_0); press(B_1); press(B_1);
        press(B_EQ);
        tests_run++;
        if (LEDForA !== 3'b101 || LEDForB !== 3'b011 || Result !== 3'b111 ||
            Carry !== 1'b0 || ResultValid !== 1'b1 || State !== 2'b11) begin
            tests_failed++;
            $display("FAIL or_basic got A=%b B=%b R=%b C=%b V=%b S=%b want 101 011 111 0 1 11",
                     LEDForA, LEDForB, Result, Carry, ResultValid, State);
        end
    endtask

    task automatic test_add_chain();
        press(B_CLR);
        press(B_1); press(B_1); press(B_1);
        press(B_ADD);
        press(B_0); press(B_0); press(B_1);
        press(B_EQ);
        tests_run++;
        if (Result !== 3'b000 || Carry !== 1'b1 || State !== 2'b11) begin
            tests_failed++;
            $display("FAIL add_carry got R=%b C=%b S=%b want 000 1 11", Result, Carry, State);
        end
        press(B_XOR);
        press(B_1); press(B_1); press(B_0);
        press(B_EQ);
        tests_run++;
        if (LEDForA !== 3'b000 || LEDForB !== 3'b110 || Result !== 3'b110 || Carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL chain_xor got A=%b B=%b R=%b C=%b want 000 110 110 0",
                     LEDForA, LEDForB, Result, Carry);
        end
    endtask

    task automatic test_overflow_entry();
        press(B_CLR);
        press(B_1); press(B_0); press(B_1); press(B_1);
        tests_run++;
        if (LEDForA !== 3'b011 || State !== 2'b00) begin
            tests_failed++;
            $display("FAIL overflow got A=%b S=%b want 011 00", LEDForA, State);
        end
        press(B_OR); press(B_1); press(B_EQ);
        press(B_1);
        tests_run++;
        if (LEDForA !== 3'b001 || LEDForB !== 3'b000 || Result !== 3'b000 ||
            ResultValid !== 1'b0 || State !== 2'b00) begin
            tests_failed++;
            $display("FAIL new_calc got A=%b B=%b R=%b V=%b S=%b want 001 000 000 0 00",
                     LEDForA, LEDForB, Result, ResultValid, State);
        end
    endtask

    task automatic test_simultaneous();
        press(B_CLR);
        press(B_1); press(B_OR); press(B_1);
        press(B_CLR | B_1);
        tests_run++;
        if (LEDForA !== 3'b000 || LEDForB !== 3'b000 || Result !== 3'b000 || State !== 2'b00) begin
            tests_failed++;
            $display("FAIL clear_wins got A=%b B=%b R=%b S=%b want zeros", LEDForA, LEDForB, Result, State);
        end
        press(B_1);
        press(B_0 | B_1);
        tests_run++;
        if (LEDForA !== 3'b010) begin
            tests_failed++;
            $display("FAIL zero_wins got A=%b want 010", LEDForA);
        end
        press(B_OR); press(B_1); press(B_1);
        press(B_AND | B_EQ);
        tests_run++;
        if (State !== 2'b01 || ResultValid !== 1'b0 || Result !== 3'b000) begin
            tests_failed++;
            $display("FAIL op_beats_eq got S=%b V=%b R=%b want 01 0 000", State, ResultValid, Result);
        end
        press(B_EQ);
        tests_run++;
        if (Result !== 3'b010 || State !== 2'b11) begin
            tests_failed++;
            $display("FAIL and_result got R=%b S=%b want 010 11", Result, State);
        end
        press(B_XOR | B_AND | B_ADD);
        press(B_1); press(B_1); press(B_EQ);
        tests_run++;
        if (Result !== 3'b001 || Carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL xor_priority got R=%b C=%b want 001 0", Result, Carry);
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] want;
        press(B_CLR);
        repeat (5) step(1'b0, B_1);
        step(1'b0, B_NONE);
`ifdef CALPOC_EDGE_DETECT_EN
        want = 3'b001;
`else
        want = 3'b111;
`endif
        tests_run++;
        if (LEDForA !== want) begin
            tests_failed++;
            $display("FAIL hold got A=%b want %b", LEDForA, want);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] want;
        press(B_OR); press(B_1);
        step(1'b1, B_1);
        step(1'b1, B_1);
        tests_run++;
        if (LEDForA !== 3'b000 || LEDForB !== 3'b000 || Result !== 3'b000 ||
            Carry !== 1'b0 || ResultValid !== 1'b0 || State !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_mid got A=%b B=%b R=%b S=%b want zeros", LEDForA, LEDForB, Result, State);
        end
        step(1'b0, B_1);
        step(1'b0, B_1);
`ifdef CALPOC_EDGE_DETECT_EN
        want = 3'b001;
`else
        want = 3'b011;
`endif
        tests_run++;
        if (LEDForA !== want) begin
            tests_failed++;
            $display("FAIL held_through_reset got A=%b want %b", LEDForA, want);
        end
        step(1'b0, B_NONE);
    endtask

    initial begin
        RST = 1'b1;
        btn = 8'h00;
        m_prev = 8'h00;
        model_clear();
        test_reset();
        test_or_basic();
        test_add_chain();
        test_overflow_entry();
        test_simultaneous();
        test_hold();
        test_reset_mid();
        repeat (3) @(negedge CLK);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
